// File: rtl/addition_normalize_round.sv
// Post-add normalise and round stage of the single-precision FP adder.
// Takes the raw signed-magnitude sum, normalises it one bit per cycle
// (or with a single right shift on carry-out), rounds to nearest-even,
// and packs the IEEE-754 result behind a valid/ready handshake.
module addition_normalize_round #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MENT_WIDTH = 23,
  parameter int unsigned EXPO_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [MENT_WIDTH+4:0]   sum_in,
  input  logic [EXPO_WIDTH-1:0]   exponent_in,
  input  logic                    sign_in,
  input  logic                    valid_in,
  output logic                    ready_out,
  output logic [DATA_WIDTH-1:0]   floating_addition_out,
  output logic                    valid_out,
  input  logic                    ready_in
);

  localparam int unsigned SUM_W = MENT_WIDTH + 5;
  localparam int unsigned SIG_W = MENT_WIDTH + 1;
  localparam int unsigned EXP_W = EXPO_WIDTH + 1;

  // Largest biased exponent; anything at or above it encodes infinity.
  localparam logic [EXP_W-1:0] EXP_MAX = EXP_W'((1 << EXPO_WIDTH) - 1);
  localparam logic [EXP_W-1:0] EXP_ONE = EXP_W'(1);

  typedef enum logic [1:0] {
    IDLE,
    NORM,
    ROUND,
    DONE
  } state_t;

  state_t           state;
  logic [SUM_W-1:0] sum_q;
  logic [EXP_W-1:0] exp_q;
  logic             sign_q;

  // Rounding datapath, only consumed in ROUND.
  logic [SIG_W-1:0]      sig;
  logic                  guard_bit;
  logic                  round_bit;
  logic                  sticky_bit;
  logic                  round_up;
  logic [SIG_W:0]        sig_inc;
  logic [SIG_W-1:0]      sig_rnd;
  logic [EXP_W-1:0]      exp_rnd;
  logic [EXPO_WIDTH-1:0] exp_field;
  logic [DATA_WIDTH-1:0] result;

  // Round-to-nearest-even, post-round renormalise, and pack.
  always_comb begin
    sig        = sum_q[SUM_W-2:3];
    guard_bit  = sum_q[2];
    round_bit  = sum_q[1];
    sticky_bit = sum_q[0];
    round_up   = guard_bit & (round_bit | sticky_bit | sig[0]);
    sig_inc    = {1'b0, sig} + (SIG_W+1)'(round_up);
    sig_rnd    = sig_inc[SIG_W-1:0];
    exp_rnd    = exp_q;
    if (sig_inc[SIG_W]) begin
      sig_rnd = sig_inc[SIG_W:1];
      exp_rnd = exp_q + EXP_ONE;
    end
    // A clear hidden bit means a subnormal, which always packs with field 0.
    exp_field = sig_rnd[SIG_W-1] ? exp_rnd[EXPO_WIDTH-1:0] : '0;
    if (exp_rnd >= EXP_MAX) begin
      result = DATA_WIDTH'({sign_q, {EXPO_WIDTH{1'b1}}, {MENT_WIDTH{1'b0}}});
    end else begin
      result = DATA_WIDTH'({sign_q, exp_field, sig_rnd[MENT_WIDTH-1:0]});
    end
  end

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state                 <= IDLE;
      sum_q                 <= '0;
      exp_q                 <= '0;
      sign_q                <= 1'b0;
      ready_out             <= 1'b1;
      valid_out             <= 1'b0;
      floating_addition_out <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (valid_in && ready_out) begin
            sum_q     <= sum_in;
            exp_q     <= EXP_W'(exponent_in);
            sign_q    <= sign_in;
            ready_out <= 1'b0;
            state     <= NORM;
          end
        end

        NORM: begin
          if (sum_q == '0) begin
            floating_addition_out <= '0;
            valid_out             <= 1'b1;
            state                 <= DONE;
          end else if (exp_q >= EXP_MAX) begin
            // Already infinite: no shifting, ROUND packs the infinity.
            state <= ROUND;
          end else if (sum_q[SUM_W-1]) begin
            sum_q <= {1'b0, sum_q[SUM_W-1:2], sum_q[1] | sum_q[0]};
            exp_q <= exp_q + EXP_ONE;
            state <= ROUND;
          end else if (!sum_q[SUM_W-2] && (exp_q > EXP_ONE)) begin
            sum_q <= {sum_q[SUM_W-2:0], 1'b0};
            exp_q <= exp_q - EXP_ONE;
          end else begin
            // Normalised, or a subnormal that must be held as is.
            state <= ROUND;
          end
        end

        ROUND: begin
          floating_addition_out <= result;
          valid_out             <= 1'b1;
          state                 <= DONE;
        end

        DONE: begin
          if (ready_in) begin
            valid_out <= 1'b0;
            ready_out <= 1'b1;
            state     <= IDLE;
          end
        end

        default: begin
          state     <= IDLE;
          ready_out <= 1'b1;
          valid_out <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_addition_normalize_round.sv
// Directed-vector bench for the FP adder normalise/round stage.
module tb_addition_normalize_round;

  logic        clk;
  logic        rst;
  logic [27:0] sum_in;
  logic [7:0]  exponent_in;
  logic        sign_in;
  logic        valid_in;
  logic        ready_out;
  logic [31:0] floating_addition_out;
  logic        valid_out;
  logic        ready_in;

  int n_tests = 0;
  int n_fail  = 0;

  addition_normalize_round dut (
    .clk                   (clk),
    .rst                   (rst),
    .sum_in                (sum_in),
    .exponent_in           (exponent_in),
    .sign_in               (sign_in),
    .valid_in              (valid_in),
    .ready_out             (ready_out),
    .floating_addition_out (floating_addition_out),
    .valid_out             (valid_out),
    .ready_in              (ready_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issue one operand; the capture edge is cycle 1. Optionally stall in DONE.
  task automatic run_op(input string tag, input logic [27:0] s, input logic [7:0] e,
                        input logic sg, input logic [31:0] exp_res, input int exp_lat,
                        input int hold);
    int   cyc;
    logic busy_ok;
    logic hold_ok;
    @(negedge clk);
    sum_in      = s;
    exponent_in = e;
    sign_in     = sg;
    valid_in    = 1'b1;
    ready_in    = 1'b0;
    @(posedge clk);
    cyc     = 1;
    busy_ok = 1'b1;
    @(negedge clk);
    valid_in = 1'b0;
    while (!valid_out && cyc < 60) begin
      if (ready_out) busy_ok = 1'b0;
      @(negedge clk);
      cyc++;
    end
    check({tag, "_lat"},  32'(cyc), 32'(exp_lat));
    check({tag, "_res"},  floating_addition_out, exp_res);
    check({tag, "_busy"}, {31'd0, busy_ok & ~ready_out}, 32'd1);
    hold_ok = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (floating_addition_out !== exp_res || valid_out !== 1'b1 || ready_out !== 1'b0)
        hold_ok = 1'b0;
    end
    if (hold > 0) check({tag, "_hold"}, {31'd0, hold_ok}, 32'd1);
    ready_in = 1'b1;
    @(negedge clk);
    ready_in = 1'b0;
    check({tag, "_vdrop"}, {31'd0, valid_out}, 32'd0);
    check({tag, "_ridle"}, {31'd0, ready_out}, 32'd1);
  endtask

  initial begin
    rst         = 1'b1;
    sum_in      = '0;
    exponent_in = '0;
    sign_in     = 1'b0;
    valid_in    = 1'b0;
    ready_in    = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ready", {31'd0, ready_out}, 32'd1);
    check("rst_valid", {31'd0, valid_out}, 32'd0);
    check("rst_out",   floating_addition_out, 32'd0);
    rst = 1'b0;

    run_op("one_plus_one", 28'h8000000, 8'd127, 1'b0, 32'h40000000, 3, 0);
    run_op("cancel3",      28'h0800000, 8'd127, 1'b0, 32'h3E000000, 6, 0);
    run_op("rne_odd_up",   28'h400000C, 8'd127, 1'b0, 32'h3F800002, 3, 0);
    run_op("rne_even",     28'h4000014, 8'd127, 1'b0, 32'h3F800002, 3, 0);
    run_op("overflow",     28'h8000000, 8'd254, 1'b0, 32'h7F800000, 3, 0);
    run_op("subnormal",    28'h2000000, 8'd1,   1'b0, 32'h00400000, 3, 0);
    run_op("zero",         28'h0000000, 8'd100, 1'b1, 32'h00000000, 2, 0);
    run_op("negative",     28'h4000000, 8'd127, 1'b1, 32'hBF800000, 3, 0);
    run_op("inf_in",       28'h4000000, 8'd255, 1'b0, 32'h7F800000, 3, 0);
    run_op("rnd_carry",    28'h7FFFFFC, 8'd127, 1'b0, 32'h40000000, 3, 0);
    run_op("sub_to_norm",  28'h3FFFFFC, 8'd1,   1'b0, 32'h00800000, 3, 0);
    run_op("backpress",    28'h8000000, 8'd127, 1'b1, 32'hC0000000, 3, 5);

    // Reset while the second left shift is in progress.
    @(negedge clk);
    sum_in      = 28'h0800000;
    exponent_in = 8'd127;
    sign_in     = 1'b0;
    valid_in    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid_in = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_valid", {31'd0, valid_out}, 32'd0);
    check("midrst_ready", {31'd0, ready_out}, 32'd1);
    check("midrst_out",   floating_addition_out, 32'd0);
    repeat (6) @(negedge clk);
    check("midrst_quiet", {31'd0, valid_out}, 32'd0);

    run_op("after_rst", 28'h8000000, 8'd127, 1'b0, 32'h40000000, 3, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
